reg_access_ctrl: RTL and testbench

Register-file access controller: the software-side initiator that drives the per-field software ports (`sw_wr`, `sw_rd`, `sw_wr_data`) of a bank of register fields. It accepts one request at a time on a native valid/ready request channel and decodes the word address to a one-hot register select. It issues a single-cycle write or read strobe to the addressed register, captures its value, and returns a response on a valid/ready response channel. It sits between the bus-protocol bridge and the field instances of one register block.

---
 rtl/reg_access_ctrl.sv | 116 +++++++++++
 tb/tb_reg_access_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// Software-side register access controller: accepts one request at a time, strobes the
// addressed register for one cycle, captures its value and returns a response.
module reg_access_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_vld,
    output logic                                req_rdy,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic                                req_wr,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    output logic [REG_NUM-1:0]                  sw_wr,
    output logic [REG_NUM-1:0]                  sw_rd,
    output logic [DATA_WIDTH-1:0]               sw_wr_data,
    input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]  reg_value,
    output logic                                ack_vld,
    input  logic                                ack_rdy,
    output logic                                ack_err,
    output logic [DATA_WIDTH-1:0]               ack_data
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   accept;
    logic [IDX_W-1:0]       idx;
    logic                   dec_err;
    logic [REG_NUM-1:0]     sel;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  rd_mux;

    assign req_rdy = (state == IDLE);
    assign accept  = req_vld & req_rdy;
    assign idx     = req_addr[ADDR_WIDTH-1:2];
    assign dec_err = (req_addr[1:0] != 2'b00) || (int'(idx) >= REG_NUM);

    // Decode happens as the request is captured so the strobe is already a flop output in ACCESS.
    always_comb begin
        sel = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            sel[k] = (int'(idx) == k);
        end
    end

    // The one-hot read strobe doubles as the read mux select.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (sw_rd[k]) rd_mux = rd_mux | reg_value[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (ack_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_wr      <= '0;
            sw_rd      <= '0;
            sw_wr_data <= '0;
            err_q      <= 1'b0;
            ack_vld    <= 1'b0;
            ack_err    <= 1'b0;
            ack_data   <= '0;
        end else begin
            sw_wr <= '0;
            sw_rd <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q <= dec_err;
                        if (!dec_err) begin
                            if (req_wr) begin
                                sw_wr      <= sel;
                                sw_wr_data <= req_wdata;
                            end else begin
                                sw_rd <= sel;
                            end
                        end
                    end
                end
                ACCESS: begin
                    ack_vld  <= 1'b1;
                    ack_err  <= err_q;
                    ack_data <= rd_mux;
                end
                RESP: begin
                    if (ack_rdy) begin
                        ack_vld  <= 1'b0;
                        ack_err  <= 1'b0;
                        ack_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a small register-field model behind the strobes.
module tb_reg_access_ctrl;

    logic             clk;
    logic             rst_n;
    logic             req_vld;
    logic             req_rdy;
    logic [7:0]       req_addr;
    logic             req_wr;
    logic [31:0]      req_wdata;
    logic [7:0]       sw_wr;
    logic [7:0]       sw_rd;
    logic [31:0]      sw_wr_data;
    logic [7:0][31:0] reg_value = '0;
    logic             ack_vld;
    logic             ack_rdy;
    logic             ack_err;
    logic [31:0]      ack_data;

    int checks = 0;
    int errors = 0;
    int nstrobe = 0;
    int nack = 0;
    int nviol = 0;

    reg_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_NUM(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_wr(req_wr), .req_wdata(req_wdata),
        .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(sw_wr_data),
        .reg_value(reg_value),
        .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_err(ack_err), .ack_data(ack_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field model: registered write on strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (sw_wr[k]) reg_value[k] <= sw_wr_data;
        end
    end

    always @(negedge clk) begin
        if ((sw_wr != 0) || (sw_rd != 0)) nstrobe++;
        if (ack_vld && ack_rdy) nack++;
        if (((sw_wr != 0) && (sw_rd != 0)) || !$onehot0(sw_wr) || !$onehot0(sw_rd)) nviol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Full transaction with ack_rdy high; starts and ends at a negedge in IDLE.
    task automatic xact(input string tag, input logic [7:0] a, input logic w, input logic [31:0] d,
                        input logic [7:0] ewr, input logic [7:0] erd, input logic eerr,
                        input logic [31:0] edata);
        req_vld = 1'b1; req_addr = a; req_wr = w; req_wdata = d;
        check({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        @(negedge clk);
        req_vld = 1'b0;
        check({tag, "_sw_wr"}, 32'(sw_wr), 32'(ewr));
        check({tag, "_sw_rd"}, 32'(sw_rd), 32'(erd));
        check({tag, "_rdy_access"}, 32'(req_rdy), 32'd0);
        if (ewr != 0) check({tag, "_wr_data"}, sw_wr_data, d);
        @(negedge clk);
        check({tag, "_ack_vld"}, 32'(ack_vld), 32'd1);
        check({tag, "_ack_err"}, 32'(ack_err), 32'(eerr));
        check({tag, "_ack_data"}, ack_data, edata);
        check({tag, "_strobe_off"}, 32'(sw_wr | sw_rd), 32'd0);
        @(negedge clk);
        check({tag, "_ack_clr"}, 32'(ack_vld), 32'd0);
        check({tag, "_rdy_idle"}, 32'(req_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        time t0;
        int  s0, a0;
        rst_n = 1'b0; req_vld = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0; ack_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_ack_vld", 32'(ack_vld), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_ack_data", ack_data, 32'd0);
        check("rst_strobes", 32'(sw_wr | sw_rd), 32'd0);
        check("rst_wr_data", sw_wr_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        xact("wr08", 8'h08, 1'b1, 32'hDEADBEEF, 8'b0000_0100, 8'h00, 1'b0, 32'h0);
        xact("wr0c", 8'h0C, 1'b1, 32'h12345678, 8'b0000_1000, 8'h00, 1'b0, 32'h0);
        xact("rd0c", 8'h0C, 1'b0, 32'h0, 8'h00, 8'b0000_1000, 1'b0, 32'h12345678);
        xact("rd08", 8'h08, 1'b0, 32'h0, 8'h00, 8'b0000_0100, 1'b0, 32'hDEADBEEF);
        xact("rd21", 8'h21, 1'b0, 32'h0, 8'h00, 8'h00, 1'b1, 32'h0);
        xact("wr20", 8'h20, 1'b1, 32'h55, 8'h00, 8'h00, 1'b1, 32'h0);
        check("err_wr_data_held", sw_wr_data, 32'h12345678);

        // Backpressure with a second request waiting.
        ack_rdy = 1'b0;
        req_vld = 1'b1; req_addr = 8'h08; req_wr = 1'b0;
        @(negedge clk);
        req_vld = 1'b0;
        check("bp_sw_rd", 32'(sw_rd), 32'h04);
        @(negedge clk);
        req_vld = 1'b1; req_addr = 8'h10; req_wr = 1'b1; req_wdata = 32'hCAFEF00D;
        s0 = nstrobe;
        for (int i = 0; i < 5; i++) begin
            check("bp_ack_vld", 32'(ack_vld), 32'd1);
            check("bp_ack_err", 32'(ack_err), 32'd0);
            check("bp_ack_data", ack_data, 32'hDEADBEEF);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
            @(negedge clk);
        end
        check("bp_no_strobe", 32'(nstrobe - s0), 32'd0);
        ack_rdy = 1'b1;
        @(negedge clk);
        check("bp_ack_clr", 32'(ack_vld), 32'd0);
        check("bp_data_clr", ack_data, 32'd0);
        check("bp_not_yet", 32'(sw_wr), 32'd0);
        xact("bp_wr10", 8'h10, 1'b1, 32'hCAFEF00D, 8'b0001_0000, 8'h00, 1'b0, 32'h0);

        // Throughput: four back-to-back transactions, one every 3 cycles.
        s0 = nstrobe; a0 = nack; t0 = $time;
        xact("tp_wr1c", 8'h1C, 1'b1, 32'h00000007, 8'b1000_0000, 8'h00, 1'b0, 32'h0);
        xact("tp_rd1c", 8'h1C, 1'b0, 32'h0, 8'h00, 8'b1000_0000, 1'b0, 32'h00000007);
        xact("tp_rd10", 8'h10, 1'b0, 32'h0, 8'h00, 8'b0001_0000, 1'b0, 32'hCAFEF00D);
        xact("tp_wr00", 8'h00, 1'b1, 32'h00000001, 8'b0000_0001, 8'h00, 1'b0, 32'h0);
        check("tp_time", 32'($time - t0), 32'd120);
        check("tp_strobes", 32'(nstrobe - s0), 32'd4);
        check("tp_acks", 32'(nack - a0), 32'd4);

        // Reset while in RESP.
        ack_rdy = 1'b0;
        req_vld = 1'b1; req_addr = 8'h00; req_wr = 1'b0;
        @(negedge clk);
        req_vld = 1'b0;
        @(negedge clk);
        check("mid_ack_vld", 32'(ack_vld), 32'd1);
        a0 = nack;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ack_vld", 32'(ack_vld), 32'd0);
        check("mid_rst_req_rdy", 32'(req_rdy), 32'd1);
        check("mid_rst_ack_data", ack_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_resp", 32'(nack - a0), 32'd0);
        check("mid_req_rdy", 32'(req_rdy), 32'd1);
        xact("post_rd1c", 8'h1C, 1'b0, 32'h0, 8'h00, 8'b1000_0000, 1'b0, 32'h00000007);

        check("strobe_onehot", 32'(nviol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
